// File: rtl/can_tx_sched_if.sv
// Transmitter-side bus between can_tx_sched and the CAN bit-level transmitter.
interface can_tx_sched_if;
  logic [7:0]  quantaDiv;
  logic [5:0]  propQuanta;
  logic [5:0]  seg1Quanta;
  logic [63:0] xmitdata;
  logic        startXmit;
  logic [3:0]  datalen;
  logic [28:0] id;
  logic        format;
  logic [1:0]  frameType;
  logic        busy;

  modport master (
    output quantaDiv, propQuanta, seg1Quanta, xmitdata, startXmit,
           datalen, id, format, frameType,
    input  busy
  );

  modport slave (
    input  quantaDiv, propQuanta, seg1Quanta, xmitdata, startXmit,
           datalen, id, format, frameType,
    output busy
  );
endinterface

// File: rtl/can_tx_sched.sv
// CAN transmit mailbox scheduler: NMB mailboxes, priority arbitration on the
// CAN identifier, one frame at a time handed to the transmitter with a
// busy-rise timeout, per-mailbox abort, done and error pulses.
module can_tx_sched #(
  parameter int NMB     = 4,
  parameter int BUSY_TO = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(NMB)-1:0]  wr_sel,
  input  logic [28:0]             wr_id,
  input  logic                    wr_format,
  input  logic [3:0]              wr_datalen,
  input  logic [63:0]             wr_data,
  input  logic [1:0]              wr_ftype,
  input  logic [NMB-1:0]          mb_abort,
  input  logic [7:0]              cfg_quantaDiv,
  input  logic [5:0]              cfg_propQuanta,
  input  logic [5:0]              cfg_seg1Quanta,
  can_tx_sched_if.master          tx,
  output logic [NMB-1:0]          mb_pending,
  output logic [NMB-1:0]          mb_done,
  output logic [NMB-1:0]          mb_err,
  output logic [$clog2(NMB)-1:0]  cur_idx
);

  localparam int IW = $clog2(NMB);
  localparam int CW = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {IDLE, ARB, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [NMB-1:0]  valid;
  logic [CW-1:0]   cnt;

  logic [28:0]     mb_id   [NMB];
  logic            mb_fmt  [NMB];
  logic [3:0]      mb_len  [NMB];
  logic [63:0]     mb_data [NMB];
  logic [1:0]      mb_ft   [NMB];

  logic [7:0]      qd_q;
  logic [5:0]      pq_q;
  logic [5:0]      s1_q;
  logic [63:0]     data_q;
  logic            start_q;
  logic [3:0]      len_q;
  logic [28:0]     id_q;
  logic            fmt_q;
  logic [1:0]      ft_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [29:0]     best_key;
  logic [29:0]     key;
  logic            sel_active;
  logic            wr_ok;

  assign mb_pending   = valid;
  assign tx.quantaDiv = qd_q;
  assign tx.propQuanta = pq_q;
  assign tx.seg1Quanta = s1_q;
  assign tx.xmitdata  = data_q;
  assign tx.startXmit = start_q;
  assign tx.datalen   = len_q;
  assign tx.id        = id_q;
  assign tx.format    = fmt_q;
  assign tx.frameType = ft_q;

  // The mailbox owned by the transmitter path is write-protected.
  assign sel_active = (state == START || state == WAIT_BUSY || state == WAIT_DONE)
                      && (wr_sel == cur_idx);
  assign wr_ok      = wr_en && !sel_active && (int'(wr_sel) < NMB);

  // Lowest key wins; strict compare keeps the lower index on ties.
  // The format bit sits below the base ID so a standard frame beats an
  // extended frame sharing the same base ID.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    best_key  = '1;
    key       = '0;
    for (int unsigned i = 0; i < NMB; i++) begin
      key = {mb_id[i][28:18], mb_fmt[i], mb_fmt[i] ? mb_id[i][17:0] : 18'b0};
      if (valid[i] && (!win_found || key < best_key)) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        best_key  = key;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NMB; i++) begin
        mb_id[i]   <= '0;
        mb_fmt[i]  <= 1'b0;
        mb_len[i]  <= '0;
        mb_data[i] <= '0;
        mb_ft[i]   <= '0;
      end
    end else if (wr_ok) begin
      mb_id[wr_sel]   <= wr_id;
      mb_fmt[wr_sel]  <= wr_format;
      mb_len[wr_sel]  <= (wr_datalen > 4'd8) ? 4'd8 : wr_datalen;
      mb_data[wr_sel] <= wr_data;
      mb_ft[wr_sel]   <= wr_ftype;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      cnt     <= '0;
      cur_idx <= '0;
      mb_done <= '0;
      mb_err  <= '0;
      start_q <= 1'b0;
      qd_q    <= '0;
      pq_q    <= '0;
      s1_q    <= '0;
      data_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      fmt_q   <= 1'b0;
      ft_q    <= '0;
    end else begin
      mb_done <= '0;
      mb_err  <= '0;
      start_q <= 1'b0;

      // Abort is applied after the write so it wins on the same mailbox;
      // only the frame already on the wire (WAIT_DONE) is immune.
      for (int unsigned i = 0; i < NMB; i++) begin
        if (wr_ok && wr_sel == IW'(i))
          valid[i] <= 1'b1;
        if (mb_abort[i] && !(state == WAIT_DONE && cur_idx == IW'(i)))
          valid[i] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|valid && !tx.busy)
            state <= ARB;
        end
        ARB: begin
          if (!win_found) begin
            state <= IDLE;
          end else if (mb_abort[win_idx]) begin
            cur_idx         <= win_idx;
            mb_err[win_idx] <= 1'b1;
            state           <= IDLE;
          end else begin
            cur_idx <= win_idx;
            id_q    <= mb_id[win_idx];
            fmt_q   <= mb_fmt[win_idx];
            len_q   <= mb_len[win_idx];
            data_q  <= mb_data[win_idx];
            ft_q    <= mb_ft[win_idx];
            qd_q    <= cfg_quantaDiv;
            pq_q    <= cfg_propQuanta;
            s1_q    <= cfg_seg1Quanta;
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          cnt <= '0;
          if (mb_abort[cur_idx]) begin
            mb_err[cur_idx] <= 1'b1;
            state           <= IDLE;
          end else begin
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (mb_abort[cur_idx]) begin
            mb_err[cur_idx] <= 1'b1;
            state           <= IDLE;
          end else if (tx.busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TO - 1)) begin
            mb_err[cur_idx] <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx.busy) begin
            valid[cur_idx]   <= 1'b0;
            mb_done[cur_idx] <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched with an event scoreboard and a simple
// transmitter model that raises busy two cycles after startXmit.
module tb_can_tx_sched;
  localparam int NMB     = 4;
  localparam int BUSY_TO = 15;
  localparam int BLEN    = 15;
  localparam int IW      = $clog2(NMB);

  typedef struct {
    int          kind;   // 0 start, 1 done, 2 err
    int          idx;
    int          cyc;    // -1 = any cycle
    logic [28:0] id;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en;
  logic [IW-1:0]  wr_sel;
  logic [28:0]    wr_id;
  logic           wr_format;
  logic [3:0]     wr_datalen;
  logic [63:0]    wr_data;
  logic [1:0]     wr_ftype;
  logic [NMB-1:0] mb_abort;
  logic [7:0]     cfg_quantaDiv;
  logic [5:0]     cfg_propQuanta;
  logic [5:0]     cfg_seg1Quanta;
  logic [NMB-1:0] mb_pending;
  logic [NMB-1:0] mb_done;
  logic [NMB-1:0] mb_err;
  logic [IW-1:0]  cur_idx;

  can_tx_sched_if txi();

  can_tx_sched #(.NMB(NMB), .BUSY_TO(BUSY_TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_sel         (wr_sel),
    .wr_id          (wr_id),
    .wr_format      (wr_format),
    .wr_datalen     (wr_datalen),
    .wr_data        (wr_data),
    .wr_ftype       (wr_ftype),
    .mb_abort       (mb_abort),
    .cfg_quantaDiv  (cfg_quantaDiv),
    .cfg_propQuanta (cfg_propQuanta),
    .cfg_seg1Quanta (cfg_seg1Quanta),
    .tx             (txi),
    .mb_pending     (mb_pending),
    .mb_done        (mb_done),
    .mb_err         (mb_err),
    .cur_idx        (cur_idx)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   b_start  = 0;
  int   b_end    = 0;
  int   ign      = 0;
  logic busy_hold = 1'b0;
  ev_t  evq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int idx, input int c, input logic [28:0] id);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = c;
    e.id   = id;
    evq.push_back(e);
  endtask

  task automatic got_event(input int kind, input int idx, input logic [28:0] id_obs);
    ev_t e;
    checks++;
    assert (evq.size() != 0) else begin
      failures++;
      $error("FAIL sb_unexpected: got kind=%0d idx=%0d at cycle %0d expected no event", kind, idx, cyc);
    end
    if (evq.size() != 0) begin
      e = evq.pop_front();
      chk("ev_kind", 64'(kind), 64'(e.kind));
      chk("ev_idx", 64'(idx), 64'(e.idx));
      if (e.cyc >= 0) chk("ev_cycle", 64'(cyc), 64'(e.cyc));
      if (kind == 0) chk("ev_id", 64'(id_obs), 64'(e.id));
    end
  endtask

  task automatic step();
    txi.busy = busy_hold || (cyc >= b_start && cyc < b_end);
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    mb_abort = '0;
    cyc++;
    @(negedge clk);
    if (txi.startXmit) begin
      got_event(0, int'(cur_idx), txi.id);
      if (ign > 0) begin
        ign--;
      end else begin
        b_start = cyc + 2;
        b_end   = cyc + 2 + BLEN;
      end
    end
    for (int i = 0; i < NMB; i++) begin
      if (mb_done[i]) got_event(1, i, '0);
      if (mb_err[i])  got_event(2, i, '0);
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic new_scen();
    cyc     = 0;
    b_start = 0;
    b_end   = 0;
    ign     = 0;
  endtask

  task automatic wr(input int sel, input logic [28:0] i, input logic f,
                    input logic [3:0] dl, input logic [63:0] d, input logic [1:0] ft);
    wr_en      = 1'b1;
    wr_sel     = IW'(sel);
    wr_id      = i;
    wr_format  = f;
    wr_datalen = dl;
    wr_data    = d;
    wr_ftype   = ft;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_en = 1'b0; wr_sel = '0; wr_id = '0; wr_format = 1'b0; wr_datalen = '0;
    wr_data = '0; wr_ftype = '0; mb_abort = '0;
    cfg_quantaDiv = 8'h11; cfg_propQuanta = 6'h05; cfg_seg1Quanta = 6'h0a;
    txi.busy = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_start", 64'(txi.startXmit), 64'h0);
    chk("rst_pending", 64'(mb_pending), 64'h0);
    chk("rst_done", 64'(mb_done), 64'h0);
    chk("rst_err", 64'(mb_err), 64'h0);
    chk("rst_quanta", 64'(txi.quantaDiv), 64'h0);
    chk("rst_id", 64'(txi.id), 64'h0);
    rst = 1'b0;
    repeat (2) step();

    // single frame, exact latency
    new_scen();
    wr(0, 29'h123 << 18, 1'b0, 4'd8, 64'h0102030405060708, 2'b00);
    push(0, 0, 3, 29'h123 << 18);
    push(1, 0, 21, '0);
    step();
    chk("s1_pend_c1", 64'(mb_pending), 64'h1);
    run_to(4);
    chk("s1_single_pulse", 64'(txi.startXmit), 64'h0);
    run_to(22);
    chk("s1_pend_end", 64'(mb_pending), 64'h0);

    // arbitration order: std 0x100 < ext 0x100 < std 0x200
    new_scen();
    busy_hold = 1'b1;
    wr(0, 29'h200 << 18, 1'b0, 4'd1, 64'hA0, 2'b00);
    step();
    wr(1, (29'h100 << 18) | 29'h00ABC, 1'b1, 4'd2, 64'hA1, 2'b00);
    step();
    wr(2, 29'h100 << 18, 1'b0, 4'd3, 64'hA2, 2'b00);
    step();
    busy_hold = 1'b0;
    push(0, 2, 5, 29'h100 << 18);
    push(1, 2, 23, '0);
    push(0, 1, 25, (29'h100 << 18) | 29'h00ABC);
    push(1, 1, 43, '0);
    push(0, 0, 45, 29'h200 << 18);
    push(1, 0, 63, '0);
    run_to(4);
    chk("s2_pend_all", 64'(mb_pending), 64'h7);
    run_to(64);
    chk("s2_pend_end", 64'(mb_pending), 64'h0);

    // busy timeout then retry
    new_scen();
    ign = 1;
    wr(1, 29'h0A5 << 18, 1'b0, 4'd4, 64'hB1, 2'b01);
    push(0, 1, 3, 29'h0A5 << 18);
    push(2, 1, 19, '0);
    push(0, 1, 21, 29'h0A5 << 18);
    push(1, 1, 39, '0);
    run_to(19);
    chk("s3_pend_after_err", 64'(mb_pending), 64'h2);
    run_to(40);
    chk("s3_pend_end", 64'(mb_pending), 64'h0);

    // abort in WAIT_BUSY, then abort ignored in WAIT_DONE
    new_scen();
    ign = 1;
    wr(0, 29'h0C0 << 18, 1'b0, 4'd2, 64'hC0, 2'b00);
    push(0, 0, 3, 29'h0C0 << 18);
    push(2, 0, 7, '0);
    run_to(6);
    mb_abort[0] = 1'b1;
    step();
    chk("s4_pend_aborted", 64'(mb_pending), 64'h0);
    run_to(9);
    wr(0, 29'h0C1 << 18, 1'b0, 4'd2, 64'hC1, 2'b00);
    push(0, 0, 12, 29'h0C1 << 18);
    push(1, 0, 30, '0);
    run_to(20);
    mb_abort[0] = 1'b1;
    step();
    chk("s4_pend_kept", 64'(mb_pending), 64'h1);
    run_to(31);
    chk("s4_pend_end", 64'(mb_pending), 64'h0);

    // datalen clamp and bit-timing hold
    new_scen();
    wr(3, 29'h0ABCDEF1, 1'b1, 4'd12, 64'h0011223344556677, 2'b10);
    push(0, 3, 3, 29'h0ABCDEF1);
    push(1, 3, 21, '0);
    run_to(3);
    chk("s5_datalen_clamp", 64'(txi.datalen), 64'h8);
    chk("s5_xmitdata", txi.xmitdata, 64'h0011223344556677);
    chk("s5_format", 64'(txi.format), 64'h1);
    chk("s5_ftype", 64'(txi.frameType), 64'h2);
    chk("s5_quanta", 64'(txi.quantaDiv), 64'h11);
    chk("s5_prop", 64'(txi.propQuanta), 64'h05);
    chk("s5_seg1", 64'(txi.seg1Quanta), 64'h0a);
    run_to(8);
    cfg_quantaDiv = 8'h22;
    run_to(10);
    chk("s5_quanta_hold", 64'(txi.quantaDiv), 64'h11);
    run_to(22);
    chk("s5_quanta_idle", 64'(txi.quantaDiv), 64'h11);
    wr(2, 29'h077 << 18, 1'b0, 4'd7, 64'hD2, 2'b00);
    push(0, 2, 25, 29'h077 << 18);
    push(1, 2, 43, '0);
    run_to(25);
    chk("s5_datalen7", 64'(txi.datalen), 64'h7);
    chk("s5_quanta_new", 64'(txi.quantaDiv), 64'h22);
    run_to(44);

    // reset in WAIT_DONE with three pending
    new_scen();
    busy_hold = 1'b1;
    wr(0, 29'h300 << 18, 1'b0, 4'd1, 64'hE0, 2'b00);
    step();
    wr(1, 29'h310 << 18, 1'b0, 4'd1, 64'hE1, 2'b00);
    step();
    wr(2, 29'h010 << 18, 1'b0, 4'd5, 64'hE2E2, 2'b11);
    step();
    busy_hold = 1'b0;
    push(0, 2, 5, 29'h010 << 18);
    run_to(12);
    chk("s6_pend_before", 64'(mb_pending), 64'h7);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_pending", 64'(mb_pending), 64'h0);
    chk("s6_rst_id", 64'(txi.id), 64'h0);
    chk("s6_rst_data", txi.xmitdata, 64'h0);
    chk("s6_rst_len", 64'(txi.datalen), 64'h0);
    chk("s6_rst_ftype", 64'(txi.frameType), 64'h0);
    chk("s6_rst_quanta", 64'(txi.quantaDiv), 64'h0);
    chk("s6_rst_cur", 64'(cur_idx), 64'h0);
    evq.delete();
    b_start = 0;
    b_end   = 0;
    txi.busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) step();
    chk("s6_pend_after", 64'(mb_pending), 64'h0);

    // write+abort same cycle, abort of a non-active mailbox
    new_scen();
    busy_hold = 1'b1;
    wr(3, 29'h040 << 18, 1'b0, 4'd1, 64'hF3, 2'b00);
    step();
    chk("s7_pend_w", 64'(mb_pending), 64'h8);
    wr(3, 29'h041 << 18, 1'b0, 4'd1, 64'hF4, 2'b00);
    mb_abort[3] = 1'b1;
    step();
    chk("s7_abort_wins", 64'(mb_pending), 64'h0);
    wr(1, 29'h042 << 18, 1'b0, 4'd1, 64'hF1, 2'b00);
    step();
    chk("s7_pend_w1", 64'(mb_pending), 64'h2);
    mb_abort[1] = 1'b1;
    step();
    chk("s7_abort_idle", 64'(mb_pending), 64'h0);
    busy_hold = 1'b0;
    repeat (8) step();

    chk("sb_empty", 64'(evq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_tx_sched.md
CAN_TX_SCHED -- requirements
Module: can_tx_sched

Interface
REQ-001 SHALL have parameter NMB, default 4, meaning number of transmit mailboxes (2..8).
REQ-002 SHALL have parameter BUSY_TO, default 15, meaning cycles allowed for busy to rise after startXmit.
REQ-003 SHALL have clk input 1, the single clock; all logic rises on posedge clk.
REQ-004 SHALL have rst input 1, reset; asynchronous, active-high.
REQ-005 SHALL have wr_en input 1, which loads the mailbox selected by wr_sel.
REQ-006 SHALL have wr_sel input $clog2(NMB), the mailbox index.
REQ-007 SHALL have wr_id input 29, wr_format input 1, wr_datalen input 4, wr_data input 64 (big endian) and wr_ftype input 2; together these are the frame contents.
REQ-008 SHALL have mb_abort input NMB, a per-mailbox cancel request.
REQ-009 SHALL have cfg_quantaDiv input 8, cfg_propQuanta input 6 and cfg_seg1Quanta input 6, the bit-timing configuration.
REQ-010 SHALL have outputs quantaDiv 8, propQuanta 6, seg1Quanta 6, xmitdata 64, startXmit 1, datalen 4, id 29, format 1 and frameType 2, all registered and driven to the transmitter.
REQ-011 SHALL have busy input 1, the transmitter-busy flag.
REQ-012 SHALL have mb_pending output NMB, mb_done output NMB (1-cycle pulse), mb_err output NMB (1-cycle pulse) and cur_idx output $clog2(NMB).

Function
REQ-013 SHALL hold, per mailbox: a valid bit plus registered id, format, datalen, data and ftype; mb_pending = valid vector.
REQ-014 SHALL accept wr_en into an idle-or-non-selected mailbox: it writes the fields and sets valid next cycle; wr_en to the mailbox currently in START/WAIT_BUSY/WAIT_DONE SHALL be ignored.
REQ-015 SHALL clamp datalen > 8 to 8 on write.
REQ-016 SHALL implement FSM states IDLE, ARB, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: when any valid bit is set and busy=0 -> ARB; otherwise stay.
REQ-018 ARB (1 cycle): SHALL compute key = {id[28:18], format, format ? id[17:0] : 18'b0} per valid mailbox; the lowest key wins (a standard frame beats an extended frame with the same base ID); on equal keys the lower index wins; latch the winner into cur_idx and the frame outputs; latch cfg_* into the bit-timing outputs; -> START.
REQ-019 START: SHALL assert startXmit for exactly 1 cycle; -> WAIT_BUSY; clear the timeout counter.
REQ-020 WAIT_BUSY: busy=1 -> WAIT_DONE; SHALL increment the counter otherwise; counter==BUSY_TO -> pulse mb_err[cur_idx], keep valid, -> IDLE.
REQ-021 WAIT_DONE: on busy falling to 0, SHALL clear valid[cur_idx], pulse mb_done[cur_idx], -> IDLE.
REQ-022 mb_abort[i] on a non-active mailbox SHALL clear valid[i] next cycle with no done/err pulse.
REQ-023 mb_abort[cur_idx] in ARB/START/WAIT_BUSY SHALL clear valid, pulse mb_err, suppress or cancel startXmit, -> IDLE.
REQ-024 mb_abort[cur_idx] in WAIT_DONE SHALL be ignored; the frame completes normally.
REQ-025 Frame and bit-timing outputs SHALL hold stable from ARB until the FSM returns to IDLE; cfg changes mid-frame SHALL not propagate.
REQ-026 wr_en and mb_abort on the same mailbox in the same cycle: abort SHALL win.
REQ-027 Minimum latency, write to startXmit: wr_en cycle N, IDLE sees valid at N+1, ARB at N+2, startXmit at N+3.

Reset
REQ-028 While rst=1, SHALL asynchronously clear all valid bits and the counter, set state IDLE, and drive startXmit, mb_done, mb_err, cur_idx, id, xmitdata, datalen, format and frameType to 0; quantaDiv, propQuanta and seg1Quanta SHALL be 0.
REQ-029 rst mid-transmission SHALL discard all pending frames with no done/err pulse.

Verification
REQ-030 Load mb0 id=0x123<<18 (std) at cycle 0; busy rises at cycle 5 and falls at cycle 20 -> startXmit single pulse at cycle 3, mb_done[0] pulse at cycle 21, mb_pending=0.
REQ-031 Load mb0 std id base 0x200, mb1 ext id base 0x100, mb2 std base 0x100 in the same idle window -> order mb2, mb1, mb0.
REQ-032 Load mb1; busy never rises -> mb_err[1] 15 cycles after WAIT_BUSY entry, mb_pending[1] stays 1, a retry startXmit follows.
REQ-033 Abort mb0 during WAIT_BUSY -> mb_err[0] pulse, valid cleared; abort mb0 during WAIT_DONE -> ignored, mb_done[0] pulse.
REQ-034 Assert rst during WAIT_DONE with 3 mailboxes pending -> all outputs 0 immediately, mb_pending=0, no pulses after release.
REQ-035 Write datalen=12 -> datalen output 8; change cfg_quantaDiv during WAIT_DONE -> quantaDiv unchanged until the next ARB.
